// File: rtl/mem_wr_pkt_pkg.sv
// Shared constants and types for the FTDI packet to SDRAM single-word write path.
package mem_wr_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         WORD_W     = 16;
    localparam int         HDR_ADDR_W = 25;

    typedef enum logic [2:0] {
        S_SYNC,
        S_A0,
        S_A1,
        S_A2,
        S_A3,
        S_LEN,
        S_DLO,
        S_DHI
    } parseState_t;

    // A FIFO entry is packed as {last, address, word}.
    function automatic int entryWidth(input int addrW);
        return addrW + WORD_W + 1;
    endfunction

endpackage

// File: rtl/mem_wr_pkt_if.sv
// Byte-stream input, SDRAM write request and status signals of mem_wr_pkt.
interface mem_wr_pkt_if
    import mem_wr_pkt_pkg::*;
#(
    parameter int ADDR_W = 25
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_idle;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ack;
    logic              pkt_done;
    logic              sync_err;
    logic              busy;

    modport slave (
        input  byte_valid, byte_data, mem_idle, wr_ack,
        output byte_ready, wr_req, wr_addr, wr_data, pkt_done, sync_err, busy
    );

    modport master (
        output byte_valid, byte_data, mem_idle, wr_ack,
        input  byte_ready, wr_req, wr_addr, wr_data, pkt_done, sync_err, busy
    );
endinterface

// File: rtl/mem_wr_pkt_fifo.sv
// wr_word_fifo: small synchronous FIFO of pending write words (DEPTH a power of two, >= 2).
module wr_word_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             mem_clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wrPtr_q;
    logic [PTR_W:0]   rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign head_o  = mem_q[rdPtr_q[PTR_W-1:0]];

    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge mem_clk) begin
        if (doPush) mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
    end
endmodule

// File: rtl/mem_wr_pkt.sv
// Parses A5-framed packets from the FTDI byte stream and issues single-word SDRAM writes.
// Optional build macro PKT_TIMEOUT_EN enables the mid-packet idle timeout.
module mem_wr_pkt
    import mem_wr_pkt_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        mem_clk,
    input  logic        reset_n,
    mem_wr_pkt_if.slave bus
);
    localparam int ENTRY_W = entryWidth(ADDR_W);

    parseState_t           state_q, state_d;
    logic [HDR_ADDR_W-1:0] hdrAddr_q, hdrAddr_d;
    logic [ADDR_W-1:0]     wordAddr_q, wordAddr_d;
    logic [7:0]            wordsLeft_q, wordsLeft_d;
    logic [7:0]            dataLo_q, dataLo_d;
    logic                  inData, accept, timeoutHit;
    logic                  fifoFull, fifoEmpty, push, pop;
    logic [ENTRY_W-1:0]    pushEntry, headEntry;
    logic                  wrReq_q, wrLast_q, pktDone_q;
    logic [ADDR_W-1:0]     wrAddr_q;
    logic [WORD_W-1:0]     wrData_q;

    // Only data bytes are back-pressured; header bytes never need FIFO space.
    assign inData         = (state_q == S_DLO) || (state_q == S_DHI);
    assign bus.byte_ready = !(inData && fifoFull);
    assign accept         = bus.byte_valid && bus.byte_ready;
    assign pop            = wrReq_q && bus.wr_ack;

    always_comb begin
        state_d     = state_q;
        hdrAddr_d   = hdrAddr_q;
        wordAddr_d  = wordAddr_q;
        wordsLeft_d = wordsLeft_q;
        dataLo_d    = dataLo_q;
        push        = 1'b0;
        pushEntry   = {wordsLeft_q == 8'd0, wordAddr_q, bus.byte_data, dataLo_q};
        if (accept) begin
            case (state_q)
                S_SYNC: if (bus.byte_data == SYNC_BYTE) state_d = S_A0;
                S_A0: begin
                    hdrAddr_d[7:0] = bus.byte_data;
                    state_d        = S_A1;
                end
                S_A1: begin
                    hdrAddr_d[15:8] = bus.byte_data;
                    state_d         = S_A2;
                end
                S_A2: begin
                    hdrAddr_d[23:16] = bus.byte_data;
                    state_d          = S_A3;
                end
                S_A3: begin
                    hdrAddr_d[HDR_ADDR_W-1] = bus.byte_data[0];
                    state_d                 = S_LEN;
                end
                S_LEN: begin
                    wordAddr_d  = ADDR_W'(hdrAddr_q);
                    wordsLeft_d = bus.byte_data;
                    state_d     = S_DLO;
                end
                S_DLO: begin
                    dataLo_d = bus.byte_data;
                    state_d  = S_DHI;
                end
                S_DHI: begin
                    push       = 1'b1;
                    wordAddr_d = wordAddr_q + ADDR_W'(1);
                    if (wordsLeft_q == 8'd0) begin
                        state_d = S_SYNC;
                    end else begin
                        wordsLeft_d = wordsLeft_q - 8'd1;
                        state_d     = S_DLO;
                    end
                end
                default: state_d = S_SYNC;
            endcase
        end
        if (timeoutHit) state_d = S_SYNC;
    end

    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SYNC;
            hdrAddr_q   <= '0;
            wordAddr_q  <= '0;
            wordsLeft_q <= '0;
            dataLo_q    <= '0;
        end else begin
            state_q     <= state_d;
            hdrAddr_q   <= hdrAddr_d;
            wordAddr_q  <= wordAddr_d;
            wordsLeft_q <= wordsLeft_d;
            dataLo_q    <= dataLo_d;
        end
    end

`ifdef PKT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idleCnt_q;
    logic            idleCycle;

    // Back-pressured cycles pause the count rather than clearing it.
    assign idleCycle  = (state_q != S_SYNC) && bus.byte_ready && !accept;
    assign timeoutHit = idleCycle && (idleCnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            idleCnt_q <= '0;
        end else if (state_q == S_SYNC || accept || timeoutHit) begin
            idleCnt_q <= '0;
        end else if (idleCycle) begin
            idleCnt_q <= idleCnt_q + TO_W'(1);
        end
    end
`else
    logic unusedTimeout;

    assign timeoutHit    = 1'b0;
    assign unusedTimeout = (TIMEOUT_CYC > 0);
`endif

    wr_word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .mem_clk (mem_clk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (pushEntry),
        .pop_i   (pop),
        .head_o  (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // The head stays queued until acknowledged; the request registers hold a stable copy.
    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            wrReq_q   <= 1'b0;
            wrLast_q  <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
            pktDone_q <= 1'b0;
        end else begin
            pktDone_q <= pop && wrLast_q;
            if (pop) begin
                wrReq_q <= 1'b0;
            end else if (!wrReq_q && !fifoEmpty && bus.mem_idle) begin
                wrReq_q                          <= 1'b1;
                {wrLast_q, wrAddr_q, wrData_q} <= headEntry;
            end
        end
    end

    assign bus.wr_req   = wrReq_q;
    assign bus.wr_addr  = wrAddr_q;
    assign bus.wr_data  = wrData_q;
    assign bus.pkt_done = pktDone_q;
    assign bus.sync_err = (accept && state_q == S_SYNC && bus.byte_data != SYNC_BYTE) || timeoutHit;
    assign bus.busy     = (state_q != S_SYNC) || !fifoEmpty;
endmodule

// File: tb/tb_mem_wr_pkt.sv
// Directed self-checking bench for mem_wr_pkt with a simple SDRAM acknowledge responder.
module tb_mem_wr_pkt;

    logic mem_clk = 1'b0;
    logic reset_n;

    mem_wr_pkt_if #(.ADDR_W(25)) bus ();

    mem_wr_pkt #(
        .ADDR_W      (25),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .mem_clk (mem_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 mem_clk = ~mem_clk;

    int          passCount    = 0;
    int          checkCount   = 0;
    int          syncErrCount = 0;
    int          pktDoneCount = 0;
    int          stableErrors = 0;
    int          idleErrors   = 0;
    logic [24:0] wrAddrQ [$];
    logic [15:0] wrDataQ [$];
    bit          ackEnable    = 1'b1;
    bit          spuriousAck  = 1'b0;
    int          ackDelay     = 2;
    int          reqCycles    = 0;
    logic [24:0] heldAddr;
    logic [15:0] heldData;
    logic        prevReq      = 1'b0;
    logic        prevIdle     = 1'b0;

    always @(negedge mem_clk) begin
        if (bus.sync_err) syncErrCount++;
        if (bus.pkt_done) pktDoneCount++;
        if (bus.wr_req && !prevReq && !prevIdle) idleErrors++;
        prevReq  = bus.wr_req;
        prevIdle = bus.mem_idle;
    end

    // Memory-side model: acknowledges after ackDelay cycles and logs every accepted write.
    initial begin
        bus.wr_ack = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (!reset_n) begin
                bus.wr_ack = 1'b0;
                reqCycles  = 0;
            end else if (bus.wr_ack) begin
                bus.wr_ack = 1'b0;
                reqCycles  = 0;
            end else if (bus.wr_req) begin
                if (reqCycles == 0) begin
                    heldAddr = bus.wr_addr;
                    heldData = bus.wr_data;
                end else if (bus.wr_addr != heldAddr || bus.wr_data != heldData) begin
                    stableErrors++;
                end
                reqCycles++;
                if (ackEnable && reqCycles >= ackDelay) begin
                    bus.wr_ack = 1'b1;
                    wrAddrQ.push_back(bus.wr_addr);
                    wrDataQ.push_back(bus.wr_data);
                end
            end else if (spuriousAck) begin
                bus.wr_ack = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int   guard = 0;
        logic ready = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!ready && guard < 2000) begin
            @(negedge mem_clk);
            ready = bus.byte_ready;
            @(posedge mem_clk);
            #1;
            guard++;
        end
        if (!ready) checkOutput("byteAccept", {31'd0, ready}, 32'd1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic sendHeader(input logic [24:0] a, input logic [7:0] n);
        applyStimulus(8'hA5);
        applyStimulus(a[7:0]);
        applyStimulus(a[15:8]);
        applyStimulus(a[23:16]);
        applyStimulus({7'd0, a[24]});
        applyStimulus(n);
    endtask

    task automatic sendWord(input logic [15:0] w);
        applyStimulus(w[7:0]);
        applyStimulus(w[15:8]);
    endtask

    task automatic waitWrites(input int target, input string tag);
        int guard = 0;
        while (wrAddrQ.size() < target && guard < 5000) begin
            @(negedge mem_clk);
            guard++;
        end
        checkOutput(tag, wrAddrQ.size(), target);
        repeat (3) @(posedge mem_clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wrReq"},   {31'd0, bus.wr_req},     32'd0);
        checkOutput({tag, "_wrAddr"},  {7'd0, bus.wr_addr},     32'd0);
        checkOutput({tag, "_wrData"},  {16'd0, bus.wr_data},    32'd0);
        checkOutput({tag, "_pktDone"}, {31'd0, bus.pkt_done},   32'd0);
        checkOutput({tag, "_syncErr"}, {31'd0, bus.sync_err},   32'd0);
        checkOutput({tag, "_busy"},    {31'd0, bus.busy},       32'd0);
        checkOutput({tag, "_ready"},   {31'd0, bus.byte_ready}, 32'd1);
    endtask

    function automatic logic [15:0] burstWord(input int i);
        logic [7:0] lo;
        lo = i[7:0];
        return {lo ^ 8'hC3, lo};
    endfunction

    initial begin
        int base;
        int errs;
        int guard;
        int pd;
        int se;

        reset_n        = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.mem_idle   = 1'b1;
        repeat (3) @(posedge mem_clk);
        #3 reset_n = 1'b1;
        @(posedge mem_clk);
        #1;
        checkResetValues("reset");

        base = wrAddrQ.size();
        pd   = pktDoneCount;
        sendHeader(25'h10, 8'd1);
        sendWord(16'h1234);
        sendWord(16'h5678);
        waitWrites(base + 2, "basicCount");
        checkOutput("basicAddr0", {7'd0, wrAddrQ[base]},     32'h10);
        checkOutput("basicData0", {16'd0, wrDataQ[base]},    32'h1234);
        checkOutput("basicAddr1", {7'd0, wrAddrQ[base + 1]}, 32'h11);
        checkOutput("basicData1", {16'd0, wrDataQ[base + 1]}, 32'h5678);
        checkOutput("basicPktDone", pktDoneCount - pd, 32'd1);
        checkOutput("basicBusy", {31'd0, bus.busy}, 32'd0);

        base = wrAddrQ.size();
        pd   = pktDoneCount;
        se   = syncErrCount;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        sendHeader(25'h20, 8'd0);
        sendWord(16'hABCD);
        waitWrites(base + 1, "syncCount");
        checkOutput("syncErrPulses", syncErrCount - se, 32'd2);
        checkOutput("syncAddr", {7'd0, wrAddrQ[base]},  32'h20);
        checkOutput("syncData", {16'd0, wrDataQ[base]}, 32'hABCD);
        checkOutput("syncPktDone", pktDoneCount - pd, 32'd1);

        base      = wrAddrQ.size();
        pd        = pktDoneCount;
        ackEnable = 1'b0;
        ackDelay  = 1;
        sendHeader(25'h100, 8'd255);
        for (int i = 0; i < 4; i++) sendWord(burstWord(i));
        repeat (5) @(posedge mem_clk);
        #1;
        checkOutput("fullReady", {31'd0, bus.byte_ready}, 32'd0);
        checkOutput("fullReq",   {31'd0, bus.wr_req},     32'd1);
        checkOutput("fullNoWrite", wrAddrQ.size() - base, 32'd0);
        ackEnable = 1'b1;
        for (int i = 4; i < 256; i++) sendWord(burstWord(i));
        waitWrites(base + 256, "burstCount");
        errs = 0;
        for (int i = 0; i < 256 && base + i < wrAddrQ.size(); i++) begin
            if (wrAddrQ[base + i] != 25'h100 + 25'(i)) errs++;
            if (wrDataQ[base + i] != burstWord(i)) errs++;
        end
        checkOutput("burstContent", errs, 32'd0);
        checkOutput("burstPktDone", pktDoneCount - pd, 32'd1);

        base     = wrAddrQ.size();
        ackDelay = 2;
        sendHeader(25'h1FFFFFF, 8'd1);
        sendWord(16'hAAAA);
        sendWord(16'h5555);
        waitWrites(base + 2, "wrapCount");
        checkOutput("wrapAddr0", {7'd0, wrAddrQ[base]},     32'h1FFFFFF);
        checkOutput("wrapAddr1", {7'd0, wrAddrQ[base + 1]}, 32'h0);
        checkOutput("wrapData1", {16'd0, wrDataQ[base + 1]}, 32'h5555);

        base         = wrAddrQ.size();
        bus.mem_idle = 1'b0;
        sendHeader(25'h40, 8'd0);
        sendWord(16'h2211);
        spuriousAck = 1'b1;
        repeat (3) @(posedge mem_clk);
        spuriousAck = 1'b0;
        repeat (17) @(posedge mem_clk);
        #1;
        checkOutput("idleNoReq",  {31'd0, bus.wr_req}, 32'd0);
        checkOutput("idleBusy",   {31'd0, bus.busy},   32'd1);
        checkOutput("idleNoWrite", wrAddrQ.size() - base, 32'd0);
        ackDelay     = 8;
        bus.mem_idle = 1'b1;
        guard        = 0;
        while (!bus.wr_req && guard < 20) begin
            @(negedge mem_clk);
            guard++;
        end
        checkOutput("idleReqRise", {31'd0, bus.wr_req}, 32'd1);
        @(posedge mem_clk);
        #1 bus.mem_idle = 1'b0;
        repeat (3) @(negedge mem_clk);
        checkOutput("idleReqHeld", {31'd0, bus.wr_req}, 32'd1);
        waitWrites(base + 1, "idleCount");
        checkOutput("idleAddr", {7'd0, wrAddrQ[base]},  32'h40);
        checkOutput("idleData", {16'd0, wrDataQ[base]}, 32'h2211);
        bus.mem_idle = 1'b1;
        ackDelay     = 2;

`ifdef PKT_TIMEOUT_EN
        base = wrAddrQ.size();
        se   = syncErrCount;
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        repeat (99) @(negedge mem_clk);
        #1;
        checkOutput("timeoutEarly", syncErrCount - se, 32'd0);
        @(negedge mem_clk);
        #1;
        checkOutput("timeoutPulse", syncErrCount - se, 32'd1);
        @(posedge mem_clk);
        #1;
        sendHeader(25'h70, 8'd0);
        sendWord(16'hBEEF);
        waitWrites(base + 1, "timeoutCount");
        checkOutput("timeoutAddr", {7'd0, wrAddrQ[base]},  32'h70);
        checkOutput("timeoutData", {16'd0, wrDataQ[base]}, 32'hBEEF);
`endif

        base      = wrAddrQ.size();
        ackEnable = 1'b0;
        sendHeader(25'h50, 8'd3);
        sendWord(16'h2211);
        sendWord(16'h4433);
        applyStimulus(8'h55);
        repeat (3) @(posedge mem_clk);
        #1;
        checkOutput("midReqPending", {31'd0, bus.wr_req}, 32'd1);
        @(posedge mem_clk);
        #3 reset_n = 1'b0;
        #1;
        checkResetValues("midReset");
        repeat (2) @(posedge mem_clk);
        #3 reset_n = 1'b1;
        ackEnable = 1'b1;
        @(posedge mem_clk);
        #1;
        sendHeader(25'h60, 8'd0);
        sendWord(16'h7766);
        waitWrites(base + 1, "postResetCount");
        checkOutput("postResetAddr", {7'd0, wrAddrQ[base]},  32'h60);
        checkOutput("postResetData", {16'd0, wrDataQ[base]}, 32'h7766);
        repeat (10) @(posedge mem_clk);
        #1;
        checkOutput("postResetNoExtra", wrAddrQ.size() - base, 32'd1);

        checkOutput("reqStable",  stableErrors, 32'd0);
        checkOutput("reqOnlyIdle", idleErrors,  32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
